// File: rtl/sa_pkg.sv
// Shared constants for the input buffer streamer: controller state codes, FSM encoding, default geometry.
package sa_pkg;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] SS_NOP    = 2'b00;
  localparam logic [1:0] SS_WRITE  = 2'b01;
  localparam logic [1:0] SS_STREAM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_DONE   = 2'b11
  } fsm_state_e;

endpackage

// File: rtl/skew_line.sv
// Per-row delay line of DELAY stages carrying data+valid; DELAY=0 is a wire.
// Shifts only while en is high, so a stall holds every stage.
module skew_line #(
  parameter int DATA_W = 8,
  parameter int DELAY  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  if (DELAY == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en};
    assign out_data  = in_data;
    assign out_valid = in_valid;
  end else begin : g_shift
    logic [DATA_W-1:0] d_q [DELAY];
    logic [DELAY-1:0]  v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DELAY; i++) d_q[i] <= '0;
        v_q <= '0;
      end else if (en) begin
        d_q[0] <= in_data;
        v_q[0] <= in_valid;
        for (int i = 1; i < DELAY; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign out_data  = d_q[DELAY-1];
    assign out_valid = v_q[DELAY-1];
  end

endmodule

// File: rtl/input_buffer_streamer.sv
// Captures controller writes, then streams stored words to the array rows with row r skewed by r cycles.
// Lane r of word k appears start+2+k+r; out_ready low freezes reads, skew lines and FSM.
module input_buffer_streamer
  import sa_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             state_signal,
  input  logic                   inp_buf_we,
  input  logic [14:0]            inp_buf_addr,
  input  logic [31:0]            inp_buf_data,
  input  logic                   out_ready,
  output logic [ROWS*DATA_W-1:0] lane_data,
  output logic [ROWS-1:0]        lane_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(ROWS + 1);

  logic [31:0]   mem [DEPTH];
  fsm_state_e    state;
  logic [FW-1:0] fill_count;
  logic [FW-1:0] rd_ptr;
  logic [CW-1:0] drain_cnt;
  logic [31:0]   mem_dat;
  logic          mem_vld;

  logic          wr_req;
  logic          addr_ok;
  logic          wr_ok;
  logic [FW-1:0] addr_p1;

  assign wr_req  = (state_signal == SS_WRITE) && inp_buf_we;
  assign addr_ok = 32'(inp_buf_addr) < DEPTH;
  assign wr_ok   = wr_req && addr_ok && (state == ST_IDLE);
  assign addr_p1 = FW'(inp_buf_addr[AW-1:0]) + FW'(1);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[inp_buf_addr[AW-1:0]] <= inp_buf_data;
  end

  // mem_dat/mem_vld is the registered read port and doubles as the lane-0 stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fill_count <= '0;
      rd_ptr     <= '0;
      drain_cnt  <= '0;
      mem_dat    <= '0;
      mem_vld    <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      wr_err <= wr_req && !wr_ok;
      if (wr_ok && (addr_p1 > fill_count)) fill_count <= addr_p1;

      if (out_ready) begin
        mem_dat <= '0;
        mem_vld <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (state_signal == SS_STREAM)
              state <= (fill_count == '0) ? ST_DONE : ST_STREAM;
          end
          ST_STREAM: begin
            mem_dat <= mem[rd_ptr[AW-1:0]];
            mem_vld <= 1'b1;
            if (rd_ptr == fill_count - FW'(1)) begin
              rd_ptr    <= '0;
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end else begin
              rd_ptr <= rd_ptr + FW'(1);
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == CW'(ROWS - 1)) state <= ST_DONE;
            else drain_cnt <= drain_cnt + CW'(1);
          end
          ST_DONE: begin
            fill_count <= '0;
            state      <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_line #(
      .DATA_W(DATA_W),
      .DELAY (r)
    ) u_skew (
      .clk      (clk),
      .rst      (rst),
      .en       (out_ready),
      .in_data  (mem_dat[r*DATA_W +: DATA_W]),
      .in_valid (mem_vld),
      .out_data (lane_data[r*DATA_W +: DATA_W]),
      .out_valid(lane_valid[r])
    );
  end

endmodule

// File: tb/tb_input_buffer_streamer.sv
// Scoreboard bench: stimulus predicts per-lane words, done/wr_err cycles and busy windows; a negedge monitor checks them.
module tb_input_buffer_streamer;
  import sa_pkg::*;

  localparam int ROWS  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] d;
    int         c;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     state_signal;
  logic           inp_buf_we;
  logic [14:0]    inp_buf_addr;
  logic [31:0]    inp_buf_data;
  logic           out_ready;
  logic [31:0]    lane_data;
  logic [3:0]     lane_valid;
  logic           busy;
  logic           done;
  logic           wr_err;

  input_buffer_streamer #(.ROWS(ROWS), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .state_signal(state_signal),
    .inp_buf_we  (inp_buf_we),
    .inp_buf_addr(inp_buf_addr),
    .inp_buf_data(inp_buf_data),
    .out_ready   (out_ready),
    .lane_data   (lane_data),
    .lane_valid  (lane_valid),
    .busy        (busy),
    .done        (done),
    .wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  ev_t         lane_q [ROWS][$];
  int          done_q[$];
  int          err_q[$];
  ev_t         e;
  int          busy_lo = -1;
  int          busy_hi = -2;
  int          stall_s = 1 << 30;
  int          stall_n = 0;
  logic [31:0] mdl_mem [DEPTH];
  int          mdl_fill = 0;

  function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic int adj(input int c);
    return (c >= stall_s) ? c + stall_n : c;
  endfunction

  function automatic bit is_busy(input int c);
    return (c >= busy_lo) && (c <= busy_hi);
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("busy", 64'(busy), 64'(is_busy(cyc)));
      for (int r = 0; r < ROWS; r++) begin
        if (!lane_valid[r]) begin
          chk("lane_idle_zero", 64'(lane_data[r*DW +: DW]), 64'(0));
        end else if (out_ready) begin
          if (lane_q[r].size() == 0) begin
            chk("lane_unexpected_valid", 64'(r), 64'(-1));
          end else begin
            e = lane_q[r].pop_front();
            chk("lane_data", 64'(lane_data[r*DW +: DW]), 64'(e.d));
            chk("lane_cycle", 64'(cyc), 64'(e.c));
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 64'(cyc), 64'(-1));
        else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
      if (wr_err) begin
        if (err_q.size() == 0) chk("wr_err_unexpected", 64'(cyc), 64'(-1));
        else chk("wr_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rst          = 1'b0;
    state_signal = SS_NOP;
    inp_buf_we   = 1'b0;
    inp_buf_addr = 15'($urandom_range(0, 31));
    inp_buf_data = $urandom();
    out_ready    = !(cyc >= stall_s && cyc < stall_s + stall_n);
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    int t = cyc;
    state_signal = SS_WRITE;
    inp_buf_we   = 1'b1;
    inp_buf_addr = 15'(a);
    inp_buf_data = d;
    if (!is_busy(t) && a < DEPTH) begin
      mdl_mem[a] = d;
      if (a + 1 > mdl_fill) mdl_fill = a + 1;
    end else begin
      err_q.push_back(t + 1);
    end
    tick();
  endtask

  task automatic do_start();
    int  t = cyc;
    int  l;
    int  dc;
    ev_t ev;
    state_signal = SS_STREAM;
    if (!is_busy(t)) begin
      l = mdl_fill;
      for (int k = 0; k < l; k++) begin
        for (int r = 0; r < ROWS; r++) begin
          ev.d = mdl_mem[k][r*DW +: DW];
          ev.c = adj(t + 2 + k + r);
          lane_q[r].push_back(ev);
        end
      end
      dc = (l == 0) ? t + 1 : adj(t + l + ROWS + 1);
      done_q.push_back(dc);
      busy_lo  = t + 1;
      busy_hi  = dc;
      mdl_fill = 0;
    end
    tick();
  endtask

  task automatic do_reset();
    int t = cyc;
    rst = 1'b1;
    for (int r = 0; r < ROWS; r++)
      while (lane_q[r].size() > 0 && lane_q[r][lane_q[r].size()-1].c >= t) lane_q[r].pop_back();
    while (done_q.size() > 0 && done_q[done_q.size()-1] >= t) done_q.pop_back();
    while (err_q.size() > 0 && err_q[err_q.size()-1] >= t) err_q.pop_back();
    if (busy_hi >= t) busy_hi = t - 1;
    mdl_fill = 0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc <= busy_hi + 1 && n < 100) begin
      tick();
      n++;
    end
    chk("idle_within_bound", 64'(n < 100), 64'(1));
    stall_s = 1 << 30;
    stall_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    state_signal = SS_NOP;
    inp_buf_we   = 1'b0;
    inp_buf_addr = '0;
    inp_buf_data = '0;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lane_data", 64'(lane_data), 64'(0));
    chk("rst_lane_valid", 64'(lane_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_wr_err", 64'(wr_err), 64'(0));
    tick();
    mon_en = 1'b1;

    // full-depth preload so every address holds known data
    for (int a = 0; a < DEPTH; a++) do_write(a, $urandom());
    do_start();
    wait_idle();

    // two words, no stall
    do_write(0, 32'h04030201);
    do_write(1, 32'h08070605);
    do_start();
    wait_idle();

    // same data with a two-cycle stall at T+3
    do_write(0, 32'h04030201);
    do_write(1, 32'h08070605);
    stall_s = cyc + 3;
    stall_n = 2;
    do_start();
    wait_idle();

    // empty buffer
    do_start();
    wait_idle();

    // out-of-range write then empty stream
    do_write(20, 32'hCAFEF00D);
    do_start();
    wait_idle();

    // write and start while streaming are dropped / ignored
    do_write(0, 32'h04030201);
    do_write(1, 32'h08070605);
    do_start();
    tick();
    do_write(5, 32'hDEADBEEF);
    do_start();
    wait_idle();
    do_write(6, 32'h0C0B0A09);
    do_start();
    wait_idle();

    // reset mid-stream, then an empty stream
    do_write(0, 32'h04030201);
    do_write(1, 32'h08070605);
    do_start();
    repeat (3) tick();
    do_reset();
    do_start();
    wait_idle();

    // randomized rounds
    for (int round = 0; round < 10; round++) begin
      nw = $urandom_range(0, 6);
      for (int i = 0; i < nw; i++) do_write($urandom_range(0, 19), $urandom());
      if (mdl_fill > 0 && $urandom_range(0, 1) == 1) begin
        stall_s = cyc + $urandom_range(2, mdl_fill + ROWS);
        stall_n = $urandom_range(1, 3);
      end
      do_start();
      wait_idle();
    end

    repeat (3) tick();
    for (int r = 0; r < ROWS; r++) chk("lane_queue_drained", 64'(lane_q[r].size()), 64'(0));
    chk("done_queue_drained", 64'(done_q.size()), 64'(0));
    chk("wr_err_queue_drained", 64'(err_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
